// File: rtl/slot_block.sv
// Axis (slot) lookup: fetches a [subject axis] operand word and walks the cell tree
// one memory read per axis bit below the MSB, returning the selected noun or an error code.
module slot_block #(
    parameter int         ADDR_W   = 10,
    parameter int         DATA_W   = 64,
    parameter int         TAG_W    = 8,
    parameter logic [2:0] SEL_CODE = 3'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        slot_start,
    input  logic [ADDR_W-1:0] slot_address,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] free_addr,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address1,
    output logic [ADDR_W-1:0] address2,
    output logic [DATA_W-1:0] write_data,
    output logic              finished,
    output logic [DATA_W-1:0] slot_data,
    output logic [TAG_W-1:0]  slot_error,
    output logic [3:0]        slot_return_sys_func,
    output logic [3:0]        slot_return_state
);
    localparam int FLD_W   = 28;
    localparam int TAG_LSB = DATA_W - TAG_W;

    typedef enum logic [3:0] {
        IDLE, FETCH_REQ, FETCH_WAIT, DECODE, WALK_REQ, WALK_WAIT, STEP, DONE, ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FLD_W-1:0]  noun_q, noun_d;
    logic [FLD_W-1:0]  axis_q, axis_d;
    logic              noun_atom_q, noun_atom_d;
    logic              axis_atom_q, axis_atom_d;
    logic [4:0]        idx_q, idx_d;
    logic              seen_low_q, seen_low_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] slot_data_q, slot_data_d;
    logic [TAG_W-1:0]  slot_error_q, slot_error_d;

    logic [4:0]        msb_pos;
    logic              step_bit;
    logic [FLD_W-1:0]  step_field;
    logic              step_atom;
    logic              go_err;
    logic [TAG_W-1:0]  err_code;
    logic              unused_sink;

    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < FLD_W; i++) begin
            if (axis_q[i]) msb_pos = 5'(i);
        end
    end

    // Bit 1 of the axis path picks the tail, bit 0 the head.
    always_comb begin
        step_bit   = axis_q[idx_q];
        step_field = step_bit ? word_q[FLD_W-1:0] : word_q[2*FLD_W-1:FLD_W];
        step_atom  = step_bit ? word_q[TAG_LSB] : word_q[TAG_LSB+1];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        noun_d       = noun_q;
        axis_d       = axis_q;
        noun_atom_d  = noun_atom_q;
        axis_atom_d  = axis_atom_q;
        idx_d        = idx_q;
        seen_low_d   = seen_low_q;
        word_d       = word_q;
        slot_data_d  = slot_data_q;
        slot_error_d = slot_error_q;
        go_err       = 1'b0;
        err_code     = '0;

        case (state_q)
            IDLE: begin
                if (slot_start == SEL_CODE) begin
                    addr_d  = slot_address;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ, WALK_REQ: begin
                seen_low_d = 1'b0;
                if (mem_ready) state_d = (state_q == FETCH_REQ) ? FETCH_WAIT : WALK_WAIT;
            end
            FETCH_WAIT: begin
                if (!mem_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    noun_d      = read_data1[2*FLD_W-1:FLD_W];
                    noun_atom_d = read_data1[TAG_LSB+1];
                    axis_d      = read_data1[FLD_W-1:0];
                    axis_atom_d = read_data1[TAG_LSB];
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                idx_d = msb_pos - 5'd1;
                if (!axis_atom_q) begin
                    go_err   = 1'b1;
                    err_code = 8'h03;
                end else if (axis_q == '0) begin
                    go_err   = 1'b1;
                    err_code = 8'h01;
                end else if (axis_q == FLD_W'(1)) begin
                    state_d = DONE;
                end else if (noun_atom_q) begin
                    go_err   = 1'b1;
                    err_code = 8'h02;
                end else begin
                    addr_d  = noun_q[ADDR_W-1:0];
                    state_d = WALK_REQ;
                end
            end
            WALK_WAIT: begin
                if (!mem_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    word_d  = read_data1;
                    state_d = STEP;
                end
            end
            STEP: begin
                noun_d      = step_field;
                noun_atom_d = step_atom;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else if (step_atom) begin
                    go_err   = 1'b1;
                    err_code = 8'h02;
                end else begin
                    idx_d   = idx_q - 5'd1;
                    addr_d  = step_field[ADDR_W-1:0];
                    state_d = WALK_REQ;
                end
            end
            DONE, ERROR: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result registers are loaded on entry so they are valid during the finished pulse.
        if (go_err) begin
            state_d      = ERROR;
            slot_data_d  = '0;
            slot_error_d = err_code;
        end else if (state_d == DONE && state_q != DONE) begin
            slot_data_d                        = '0;
            slot_data_d[TAG_LSB+1]             = noun_atom_d;
            slot_data_d[2*FLD_W-1:FLD_W]       = noun_d;
            slot_error_d                       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            noun_q       <= '0;
            axis_q       <= '0;
            noun_atom_q  <= 1'b0;
            axis_atom_q  <= 1'b0;
            idx_q        <= '0;
            seen_low_q   <= 1'b0;
            word_q       <= '0;
            slot_data_q  <= '0;
            slot_error_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            noun_q       <= noun_d;
            axis_q       <= axis_d;
            noun_atom_q  <= noun_atom_d;
            axis_atom_q  <= axis_atom_d;
            idx_q        <= idx_d;
            seen_low_q   <= seen_low_d;
            word_q       <= word_d;
            slot_data_q  <= slot_data_d;
            slot_error_q <= slot_error_d;
        end
    end

    assign mem_execute          = (state_q == FETCH_REQ || state_q == WALK_REQ) && mem_ready;
    assign mem_func             = 2'b00;
    assign address1             = addr_q;
    assign address2             = '0;
    assign write_data           = '0;
    assign finished             = (state_q == DONE) || (state_q == ERROR);
    assign slot_data            = slot_data_q;
    assign slot_error           = slot_error_q;
    assign slot_return_sys_func = finished ? 4'h1 : 4'h0;
    assign slot_return_state    = finished ? 4'h2 : 4'h0;

    assign unused_sink = ^{read_data2, free_addr, word_q[DATA_W-1:TAG_LSB+2]};
endmodule

// File: tb/tb_slot_block.sv
// Directed and randomized checks of slot_block against a recursive axis-walk reference model
// and a variable-latency read-only memory.
module tb_slot_block;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  slot_start = 3'd0;
    logic [9:0]  slot_address = '0;
    logic        mem_ready;
    logic [63:0] read_data1;
    logic [63:0] read_data2 = '0;
    logic [9:0]  free_addr = '0;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [9:0]  address1, address2;
    logic [63:0] write_data, slot_data;
    logic        finished;
    logic [7:0]  slot_error;
    logic [3:0]  slot_return_sys_func, slot_return_state;

    slot_block dut (
        .clk(clk), .rst(rst), .slot_start(slot_start), .slot_address(slot_address),
        .mem_ready(mem_ready), .read_data1(read_data1), .read_data2(read_data2),
        .free_addr(free_addr), .mem_execute(mem_execute), .mem_func(mem_func),
        .address1(address1), .address2(address2), .write_data(write_data),
        .finished(finished), .slot_data(slot_data), .slot_error(slot_error),
        .slot_return_sys_func(slot_return_sys_func), .slot_return_state(slot_return_state)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:1023];
    int          lat = 1;
    int          cnt = 0;
    logic [9:0]  raddr = '0;
    int          errors = 0;
    int          checks = 0;
    int          strobe_cnt = 0;
    int          strobe_bad = 0;

    // Memory: a strobe drops ready, data appears with ready after lat cycles.
    always @(posedge clk) begin
        if (!rst) begin
            mem_ready  <= 1'b1;
            cnt        <= 0;
            read_data1 <= '0;
        end else if (mem_execute) begin
            mem_ready <= 1'b0;
            cnt       <= lat;
            raddr     <= address1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mem_ready  <= 1'b1;
                read_data1 <= mem[raddr];
            end
        end
    end

    always @(negedge clk) begin
        if (rst && mem_execute) begin
            strobe_cnt <= strobe_cnt + 1;
            if (!mem_ready || mem_func != 2'b00) strobe_bad <= strobe_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Axis semantics: /1 = a, /2a = head of /a, /(2a+1) = tail of /a.
    function automatic void ref_model(input int op, output logic [7:0] err,
                                      output logic [63:0] data, output int nreads);
        logic [63:0] w;
        int          axis;
        int          path[$];
        logic [27:0] subj;
        logic        atom;
        w = mem[op];
        nreads = 1;
        err = 8'h00;
        data = '0;
        if (!w[56]) begin err = 8'h03; return; end
        axis = int'(w[27:0]);
        if (axis == 0) begin err = 8'h01; return; end
        subj = w[55:28];
        atom = w[57];
        while (axis > 1) begin
            path.push_front(axis % 2);
            axis = axis / 2;
        end
        foreach (path[i]) begin
            if (atom) begin err = 8'h02; return; end
            w = mem[subj[9:0]];
            nreads++;
            if (path[i] == 1) begin subj = w[27:0];  atom = w[56]; end
            else              begin subj = w[55:28]; atom = w[57]; end
        end
        data = {6'b0, atom, 1'b0, subj, 28'b0};
    endfunction

    task automatic run_op(input int op, input int l, input string nm);
        logic [7:0]  e_err;
        logic [63:0] e_data;
        int          e_reads, r0, cyc;
        ref_model(op, e_err, e_data, e_reads);
        lat = l;
        @(negedge clk);
        r0 = strobe_cnt;
        slot_address = 10'(op);
        slot_start = 3'd5;
        @(negedge clk);
        slot_start = 3'd2;
        cyc = 1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "/finished"}, 64'(finished), 64'd1);
        chk({nm, "/cycles"}, 64'(cyc), 64'(e_reads * (l + 3) + 1));
        chk({nm, "/reads"}, 64'(strobe_cnt - r0), 64'(e_reads));
        chk({nm, "/data"}, slot_data, e_data);
        chk({nm, "/error"}, 64'(slot_error), 64'(e_err));
        chk({nm, "/ret_func"}, 64'(slot_return_sys_func), 64'h1);
        chk({nm, "/ret_state"}, 64'(slot_return_state), 64'h2);
        @(negedge clk);
        chk({nm, "/pulse_end"}, 64'(finished), 64'd0);
        chk({nm, "/ret_idle"}, 64'({slot_return_sys_func, slot_return_state}), 64'h0);
        chk({nm, "/data_hold"}, slot_data, e_data);
        chk({nm, "/error_hold"}, 64'(slot_error), 64'(e_err));
    endtask

    function automatic logic [63:0] rand_word();
        logic ha, ta;
        logic [27:0] h, t;
        ha = ($urandom_range(0, 3) == 0);
        ta = ($urandom_range(0, 3) == 0);
        h = ha ? 28'($urandom) : 28'($urandom_range(10, 49));
        t = ta ? 28'($urandom) : 28'($urandom_range(10, 49));
        return {6'b0, ha, ta, h, t};
    endfunction

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "/finished"}, 64'(finished), 64'd0);
        chk({nm, "/mem_execute"}, 64'(mem_execute), 64'd0);
        chk({nm, "/slot_data"}, slot_data, 64'd0);
        chk({nm, "/slot_error"}, 64'(slot_error), 64'd0);
        chk({nm, "/address1"}, 64'(address1), 64'd0);
        chk({nm, "/misc"}, 64'({mem_func, address2, slot_return_sys_func, slot_return_state}), 64'd0);
        chk({nm, "/write_data"}, write_data, 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        int          n, fin_seen;
        for (int a = 0; a < 1024; a++) mem[a] = '0;

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;

        mem[1] = {8'h01, 28'd2, 28'd1};
        run_op(1, 1, "axis1");

        mem[2] = {8'h03, 28'd5, 28'd7};
        mem[4] = {8'h01, 28'd2, 28'd2};
        run_op(4, 1, "axis2");

        mem[6] = {8'h01, 28'd2, 28'd0};
        run_op(6, 1, "axis0");
        mem[7] = {8'h01, 28'd2, 28'd6};
        run_op(7, 1, "axis6_atom");
        mem[8] = {8'h00, 28'd2, 28'd3};
        run_op(8, 1, "tail_not_atom");

        mem[2] = {8'h02, 28'd5, 28'd3};
        mem[3] = {8'h03, 28'd8, 28'd9};
        mem[5] = {8'h01, 28'd2, 28'd7};
        run_op(5, 1, "axis7");
        run_op(5, 3, "axis7_lat3");

        // Reset while the second read is outstanding.
        lat = 3;
        @(negedge clk);
        slot_address = 10'd5;
        slot_start = 3'd5;
        n = 0;
        fin_seen = 0;
        for (int c = 0; c < 200 && n < 2; c++) begin
            @(negedge clk);
            slot_start = 3'd0;
            if (mem_execute) n++;
            if (finished) fin_seen++;
        end
        chk("rst_mid/second_read", 64'(n), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_zero_outputs("rst_mid");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (finished) fin_seen++;
        end
        chk("rst_mid/no_pulse", 64'(fin_seen), 64'd0);
        mem[9] = {8'h01, 28'd3, 28'd3};
        run_op(9, 1, "axis3_after_rst");

        for (int t = 0; t < 25; t++) begin
            int axis, sel;
            for (int a = 10; a < 50; a++) mem[a] = rand_word();
            w = rand_word();
            axis = $urandom_range(1, 255);
            sel = $urandom_range(0, 9);
            if (sel == 0) axis = 0;
            w[27:0] = 28'(axis);
            w[56] = (sel != 1);
            mem[60] = w;
            run_op(60, $urandom_range(1, 4), $sformatf("rand%0d", t));
        end

        chk("strobe_protocol", 64'(strobe_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
